cpu_checker_gen: RTL and testbench

//  Parametrised next-generation CPU trace-line checker. Consumes one ASCII char per clk and

---
 rtl/cpu_checker_gen_if.sv | 25 ++
 rtl/cpu_checker_gen.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_cpu_checker_gen.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_checker_gen_if.sv
// Trace-checker character stream and result bundle.
// Latency: none; wires only.
// Backpressure: none; one character is consumed every clock.
interface cpu_checker_gen_if #(
    parameter int COUNT_W = 16
);
    logic [7:0]         char;
    logic [15:0]        freq;
    logic [1:0]         format_type;
    logic [4:0]         error_code;
    logic [COUNT_W-1:0] rec_count;
    logic [COUNT_W-1:0] err_count;

    // Stimulus side: drives characters and clock frequency, observes results
    modport master (
        output char, freq,
        input  format_type, error_code, rec_count, err_count
    );

    // Checker side
    modport slave (
        input  char, freq,
        output format_type, error_code, rec_count, err_count
    );
endinterface

// File: rtl/cpu_checker_gen.sv
// CPU trace-line checker: parses register/memory write records and flags field errors.
// Latency: result appears for one cycle, the cycle after the closing '#' is sampled.
// Backpressure: none; one character per clock is always accepted.
module cpu_checker_gen #(
    parameter int          TIME_DIGITS = 4,
    parameter int          GRF_DIGITS  = 4,
    parameter int          NUM_GRF     = 32,
    parameter logic [31:0] PC_LO       = 32'h3000,
    parameter logic [31:0] PC_HI       = 32'h4fff,
    parameter logic [31:0] ADDR_HI     = 32'h2fff,
    parameter bit          ALLOW_UPPER = 1'b0,
    parameter int          COUNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    cpu_checker_gen_if.slave bus
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_HAT      = 4'd1;
    localparam logic [3:0] S_TIME     = 4'd2;
    localparam logic [3:0] S_AT_PC    = 4'd3;
    localparam logic [3:0] S_PC       = 4'd4;
    localparam logic [3:0] S_COLON_SP = 4'd5;
    localparam logic [3:0] S_DOLLAR   = 4'd6;
    localparam logic [3:0] S_STAR     = 4'd7;
    localparam logic [3:0] S_GRF      = 4'd8;
    localparam logic [3:0] S_ADDR     = 4'd9;
    localparam logic [3:0] S_SP       = 4'd10;
    localparam logic [3:0] S_LT       = 4'd11;
    localparam logic [3:0] S_EQ_SP    = 4'd12;
    localparam logic [3:0] S_DATA     = 4'd13;
    localparam logic [3:0] S_DONE     = 4'd14;

    localparam logic [7:0] CH_HAT    = 8'h5e;
    localparam logic [7:0] CH_AT     = 8'h40;
    localparam logic [7:0] CH_COLON  = 8'h3a;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_STAR   = 8'h2a;
    localparam logic [7:0] CH_LT     = 8'h3c;
    localparam logic [7:0] CH_EQ     = 8'h3d;
    localparam logic [7:0] CH_HASH   = 8'h23;

    localparam logic [7:0] T_MAX   = 8'(TIME_DIGITS);
    localparam logic [7:0] G_MAX   = 8'(GRF_DIGITS);
    localparam logic [7:0] HEX_LEN = 8'd8;

    logic [3:0]         state;
    logic [7:0]         cnt;
    logic [31:0]        t_val;
    logic [31:0]        pc_val;
    logic [31:0]        g_val;
    logic [31:0]        a_val;
    logic               is_mem;
    logic [15:0]        freq_q;
    logic               have_prev;
    logic [31:0]        prev_time;
    logic [1:0]         fmt_q;
    logic [4:0]         err_q;
    logic [COUNT_W-1:0] rec_cnt_q;
    logic [COUNT_W-1:0] err_cnt_q;

    logic [7:0]  c;
    logic        is_dec;
    logic        is_hex;
    logic [3:0]  hex_v;
    logic [31:0] t_mask;
    logic [4:0]  err_vec;

    assign c = bus.char;

    // Classify the incoming character as decimal / hex digit and give its value
    always_comb begin
        is_dec = (c >= 8'h30) && (c <= 8'h39);
        is_hex = 1'b0;
        hex_v  = 4'd0;
        if (is_dec) begin
            is_hex = 1'b1;
            hex_v  = c[3:0];
        end else if ((c >= 8'h61) && (c <= 8'h66)) begin
            is_hex = 1'b1;
            hex_v  = c[3:0] + 4'd9;
        end else if (ALLOW_UPPER && (c >= 8'h41) && (c <= 8'h46)) begin
            is_hex = 1'b1;
            hex_v  = c[3:0] + 4'd9;
        end
    end

    // Field checks on the captured record, used when '#' closes it
    always_comb begin
        t_mask     = ({16'd0, freq_q} >> 2) - 32'd1;
        err_vec    = 5'd0;
        err_vec[0] = |(t_val & t_mask);
        err_vec[1] = (pc_val[1:0] != 2'd0) || (pc_val < PC_LO) || (pc_val > PC_HI);
        err_vec[2] = is_mem && ((a_val[1:0] != 2'd0) || (a_val > ADDR_HI));
        err_vec[3] = !is_mem && (g_val >= 32'(NUM_GRF));
        err_vec[4] = have_prev && (t_val < prev_time);
    end

    // Record parser, result strobe and saturating counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            t_val     <= 32'd0;
            pc_val    <= 32'd0;
            g_val     <= 32'd0;
            a_val     <= 32'd0;
            is_mem    <= 1'b0;
            freq_q    <= 16'd0;
            have_prev <= 1'b0;
            prev_time <= 32'd0;
            fmt_q     <= 2'd0;
            err_q     <= 5'd0;
            rec_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            fmt_q <= 2'd0;
            err_q <= 5'd0;
            if (c == CH_HAT) begin
                // A caret restarts parsing from any state
                state  <= S_HAT;
                cnt    <= 8'd0;
                t_val  <= 32'd0;
                pc_val <= 32'd0;
                g_val  <= 32'd0;
                a_val  <= 32'd0;
                is_mem <= 1'b0;
            end else begin
                case (state)
                    S_HAT: begin
                        if (is_dec) begin
                            state <= S_TIME;
                            t_val <= {28'd0, c[3:0]};
                            cnt   <= 8'd1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_TIME: begin
                        if (is_dec && (cnt != T_MAX)) begin
                            t_val <= t_val * 32'd10 + {28'd0, c[3:0]};
                            cnt   <= cnt + 8'd1;
                        end else if (c == CH_AT) begin
                            state  <= S_AT_PC;
                            freq_q <= bus.freq;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_AT_PC: begin
                        if (is_hex) begin
                            state  <= S_PC;
                            pc_val <= {28'd0, hex_v};
                            cnt    <= 8'd1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_PC: begin
                        if (is_hex && (cnt != HEX_LEN)) begin
                            pc_val <= {pc_val[27:0], hex_v};
                            cnt    <= cnt + 8'd1;
                        end else if ((c == CH_COLON) && (cnt == HEX_LEN)) begin
                            state <= S_COLON_SP;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_COLON_SP: begin
                        if (c == CH_SPACE) begin
                            state <= S_COLON_SP;
                        end else if (c == CH_DOLLAR) begin
                            state  <= S_DOLLAR;
                            is_mem <= 1'b0;
                        end else if (c == CH_STAR) begin
                            state  <= S_STAR;
                            is_mem <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_DOLLAR: begin
                        if (is_dec) begin
                            state <= S_GRF;
                            g_val <= {28'd0, c[3:0]};
                            cnt   <= 8'd1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_GRF: begin
                        if (is_dec && (cnt != G_MAX)) begin
                            g_val <= g_val * 32'd10 + {28'd0, c[3:0]};
                            cnt   <= cnt + 8'd1;
                        end else if (c == CH_SPACE) begin
                            state <= S_SP;
                        end else if (c == CH_LT) begin
                            state <= S_LT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_STAR: begin
                        if (is_hex) begin
                            state <= S_ADDR;
                            a_val <= {28'd0, hex_v};
                            cnt   <= 8'd1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_ADDR: begin
                        if (is_hex && (cnt != HEX_LEN)) begin
                            a_val <= {a_val[27:0], hex_v};
                            cnt   <= cnt + 8'd1;
                        end else if ((c == CH_SPACE) && (cnt == HEX_LEN)) begin
                            state <= S_SP;
                        end else if ((c == CH_LT) && (cnt == HEX_LEN)) begin
                            state <= S_LT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_SP: begin
                        if (c == CH_SPACE) begin
                            state <= S_SP;
                        end else if (c == CH_LT) begin
                            state <= S_LT;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_LT: begin
                        state <= (c == CH_EQ) ? S_EQ_SP : S_IDLE;
                    end
                    S_EQ_SP: begin
                        if (c == CH_SPACE) begin
                            state <= S_EQ_SP;
                        end else if (is_hex) begin
                            state <= S_DATA;
                            cnt   <= 8'd1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    S_DATA: begin
                        // Data value itself is not checked, only its digit count
                        if (is_hex && (cnt != HEX_LEN)) begin
                            cnt <= cnt + 8'd1;
                        end else if ((c == CH_HASH) && (cnt == HEX_LEN)) begin
                            state     <= S_DONE;
                            fmt_q     <= is_mem ? 2'b10 : 2'b01;
                            err_q     <= err_vec;
                            prev_time <= t_val;
                            have_prev <= 1'b1;
                            if (rec_cnt_q != {COUNT_W{1'b1}}) begin
                                rec_cnt_q <= rec_cnt_q + 1'b1;
                            end
                            if ((err_vec != 5'd0) && (err_cnt_q != {COUNT_W{1'b1}})) begin
                                err_cnt_q <= err_cnt_q + 1'b1;
                            end
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        // IDLE and DONE wait for the next caret
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.format_type = fmt_q;
    assign bus.error_code  = err_q;
    assign bus.rec_count   = rec_cnt_q;
    assign bus.err_count   = err_cnt_q;

endmodule

// File: tb/tb_cpu_checker_gen.sv
// Randomised record stream against a field-level reference model.
// Latency: checks every output one cycle after each character is presented.
// Backpressure: none; one character per clock.
module tb_cpu_checker_gen;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cpu_checker_gen_if #(.COUNT_W(16)) bus ();
    cpu_checker_gen_if #(.COUNT_W(2))  bus2 ();

    assign bus2.char = bus.char;
    assign bus2.freq = bus.freq;

    cpu_checker_gen dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Narrow-counter copy to reach counter saturation quickly
    cpu_checker_gen #(.COUNT_W(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    int          n_chk  = 0;
    int          n_fail = 0;
    int unsigned m_rec;
    int unsigned m_err;
    bit          m_have_prev;
    int unsigned m_prev;
    logic [1:0]  p_fmt;
    logic [4:0]  p_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int unsigned sat3(input int unsigned v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic check_outputs();
        chk("format_type", {30'd0, bus.format_type}, {30'd0, p_fmt});
        chk("error_code", {27'd0, bus.error_code}, {27'd0, p_err});
        chk("rec_count", {16'd0, bus.rec_count}, m_rec);
        chk("err_count", {16'd0, bus.err_count}, m_err);
        chk("rec_count_sat", {30'd0, bus2.rec_count}, sat3(m_rec));
        chk("err_count_sat", {30'd0, bus2.err_count}, sat3(m_err));
    endtask

    // Check the result of the previous character, then present the next one
    task automatic drive(input logic [7:0] c, input logic [15:0] f, input bit fin,
                         input logic [1:0] fmt, input logic [4:0] e, input int unsigned t);
        @(negedge clk);
        check_outputs();
        bus.char = c;
        bus.freq = f;
        p_fmt = 2'd0;
        p_err = 5'd0;
        if (fin) begin
            p_fmt = fmt;
            p_err = e;
            m_rec++;
            if (e != 5'd0) m_err++;
            m_have_prev = 1'b1;
            m_prev = t;
        end
    endtask

    task automatic send_line(input string s, input bit good, input bit is_mem,
                             input int unsigned t, input int unsigned pc, input int unsigned ga,
                             input int unsigned f, input bit wiggle);
        logic [4:0]  e;
        logic [1:0]  fmt;
        logic [15:0] fnow;
        bit          seen_at;
        e[0] = (t % (f / 4)) != 0;
        e[1] = (pc % 4 != 0) || (pc < 32'h3000) || (pc > 32'h4fff);
        e[2] = is_mem && ((ga % 4 != 0) || (ga > 32'h2fff));
        e[3] = !is_mem && (ga >= 32);
        e[4] = m_have_prev && (t < m_prev);
        fmt = is_mem ? 2'b10 : 2'b01;
        seen_at = 1'b0;
        for (int i = 0; i < s.len(); i++) begin
            fnow = (wiggle && seen_at) ? 16'(4 << $urandom_range(0, 6)) : 16'(f);
            drive(s[i], fnow, good && (i == s.len() - 1), fmt, e, t);
            if (s[i] == "@") seen_at = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.char = 8'h00;
        #1;
        m_rec = 0;
        m_err = 0;
        m_have_prev = 1'b0;
        m_prev = 0;
        p_fmt = 2'd0;
        p_err = 5'd0;
        check_outputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic string hex8(input logic [31:0] v);
        return $sformatf("%08h", v);
    endfunction

    function automatic string spaces(input int n);
        string r;
        r = "";
        for (int i = 0; i < n; i++) r = {r, " "};
        return r;
    endfunction

    initial begin
        string       line, tstr, pcstr, fld, rel, dstr, tmp;
        bit          is_mem, good;
        int unsigned t, pc, ga, f, mode, sel;
        logic [31:0] data;

        reset    = 1'b1;
        bus.char = 8'h00;
        bus.freq = 16'd16;
        do_reset();

        // Directed records
        send_line("^12@00003000: $3 <= 0000abcd#", 1, 0, 12, 32'h3000, 3, 16, 0);
        send_line("^8@00003002:  *00003000<=00000001#", 1, 1, 8, 32'h3002, 32'h3000, 16, 0);
        send_line("^12@0000300: $1 <= 00000000#", 0, 0, 12, 32'h300, 1, 16, 0);
        send_line("^12@00003000: $3 <= 0000abcd#", 1, 0, 12, 32'h3000, 3, 16, 0);
        send_line("^5^40@00003004: $32 <= 00000000#", 1, 0, 40, 32'h3004, 32, 16, 0);
        send_line("^20@00003000: $1 <= 00000000#", 1, 0, 20, 32'h3000, 1, 16, 0);
        send_line("^16@00003000: $1 <= 00000000#", 1, 0, 16, 32'h3000, 1, 16, 0);
        send_line("^16@00003000: $1 <= 00000000#", 1, 0, 16, 32'h3000, 1, 16, 1);
        send_line("^12@000", 0, 0, 12, 32'h3000, 1, 16, 0);
        do_reset();
        send_line("03000: $1 <= 0000abcd#", 0, 0, 12, 32'h3000, 1, 16, 0);
        send_line("^12@00003000: $1 <= 0000ABCD#", 0, 0, 12, 32'h3000, 1, 16, 0);
        send_line("^4@00004ffc: *00002ffc <= ffffffff#", 1, 1, 4, 32'h4ffc, 32'h2ffc, 16, 0);

        // Random records, a share of them malformed
        for (int n = 0; n < 90; n++) begin
            is_mem = 1'($urandom_range(0, 1));
            f      = 4 << $urandom_range(0, 3);
            t      = $urandom_range(0, 60);
            sel    = $urandom_range(0, 3);
            case (sel)
                0:       pc = $urandom_range(32'h2ff8, 32'h3008);
                1:       pc = $urandom_range(32'h4ff8, 32'h5008);
                default: pc = 32'h3000 + 4 * $urandom_range(0, 32'h7ff);
            endcase
            if (is_mem) ga = ($urandom_range(0, 1) == 1) ? $urandom_range(32'h2ff0, 32'h3008)
                                                         : 4 * $urandom_range(0, 32'hbff);
            else        ga = $urandom_range(0, 40);
            data = $urandom;
            mode = $urandom_range(0, 9);
            good = (mode <= 3);

            tstr = (mode == 4) ? $sformatf("%05d", t) : $sformatf("%0d", t);
            tmp  = hex8(pc);
            if (mode == 5)      pcstr = tmp.substr(1, 7);
            else if (mode == 6) pcstr = {tmp, "0"};
            else                pcstr = tmp;
            if (is_mem) fld = (mode == 7) ? {"*", hex8(ga), "1"} : {"*", hex8(ga)};
            else        fld = (mode == 7) ? $sformatf("$%05d", ga) : $sformatf("$%0d", ga);
            rel = (mode == 8) ? "< =" : "<=";
            if (mode == 9) begin
                tmp  = hex8({data[31:4], 4'ha});
                dstr = tmp.toupper();
            end else begin
                dstr = hex8(data);
            end
            line = {"^", tstr, "@", pcstr, ":", spaces($urandom_range(0, 2)), fld,
                    spaces($urandom_range(0, 2)), rel, spaces($urandom_range(0, 2)), dstr, "#"};
            send_line(line, good, is_mem, t, pc, ga, f, 1'($urandom_range(0, 1)));
        end

        drive(8'h00, 16'd16, 0, 2'd0, 5'd0, 0);
        @(negedge clk);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
